// File: rtl/dmem_responder_if.sv
// Load/store request bus between the memory-stage pipeline and the data memory responder.
// The fault line exists only when DMEM_OOR_FAULT_EN is defined.
interface dmem_responder_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    load;
  logic                    store;
  logic [ADDRESS_BITS-1:0] address;
  logic [DATA_WIDTH-1:0]   store_data;
  logic                    ready;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   load_data;
`ifdef DMEM_OOR_FAULT_EN
  logic                    fault;

  modport master (output load, store, address, store_data,
                  input  ready, valid, load_data, fault);
  modport slave  (input  load, store, address, store_data,
                  output ready, valid, load_data, fault);
`else
  modport master (output load, store, address, store_data,
                  input  ready, valid, load_data);
  modport slave  (input  load, store, address, store_data,
                  output ready, valid, load_data);
`endif
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with programmable wait states; one request in flight at a time.
// Optional DMEM_OOR_FAULT_EN: out-of-range requests are suppressed and flagged on fault.
module dmem_responder #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int INDEX_BITS   = 10,
  parameter int LATENCY      = 2
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LATENCY_L = 4'(LATENCY);
  localparam int         DEPTH     = 1 << INDEX_BITS;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [3:0]              count_r;
  logic [3:0]              count_nxt_s;
  logic                    ready_r;
  logic                    ready_nxt_s;
  logic                    valid_r;
  logic                    valid_nxt_s;
  logic                    accept_s;
  logic                    access_s;
  logic                    oor_s;
  logic [INDEX_BITS-1:0]   index_s;
  logic [ADDRESS_BITS-1:0] address_r;
  logic [DATA_WIDTH-1:0]   store_data_r;
  logic                    is_store_r;
  logic [DATA_WIDTH-1:0]   load_data_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  // Marker block left in the hierarchy when the parameter set is unusable.
  if (CORE < 0 || INDEX_BITS > ADDRESS_BITS || LATENCY < 0 || LATENCY > 15) begin : g_invalid_config
  end

  // Address decode of the latched request.
  always_comb begin
    index_s = address_r[INDEX_BITS-1:0];
`ifdef DMEM_OOR_FAULT_EN
    oor_s   = (address_r >> INDEX_BITS) != {ADDRESS_BITS{1'b0}};
`else
    oor_s   = 1'b0;
`endif
  end

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    ready_nxt_s = 1'b0;
    valid_nxt_s = 1'b0;
    accept_s    = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.load || bus.store) begin
          accept_s    = 1'b1;
          count_nxt_s = LATENCY_L;
          state_nxt_s = BUSY;
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      BUSY: begin
        if (count_r != 4'd0) begin
          count_nxt_s = count_r - 4'd1;
        end else begin
          access_s    = 1'b1;
          valid_nxt_s = 1'b1;
          state_nxt_s = DONE;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        ready_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s = IDLE;
        count_nxt_s = 4'd0;
        ready_nxt_s = 1'b1;
      end
    endcase
  end

  // FSM state, request latch and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      count_r      <= 4'd0;
      ready_r      <= 1'b1;
      valid_r      <= 1'b0;
      address_r    <= {ADDRESS_BITS{1'b0}};
      store_data_r <= {DATA_WIDTH{1'b0}};
      is_store_r   <= 1'b0;
      load_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      ready_r <= ready_nxt_s;
      valid_r <= valid_nxt_s;
      if (accept_s) begin
        address_r    <= bus.address;
        store_data_r <= bus.store_data;
        is_store_r   <= bus.store;
      end
      if (access_s && !is_store_r) begin
        load_data_r <= oor_s ? {DATA_WIDTH{1'b0}} : mem_r[index_s];
      end
    end
  end

  // Array write happens only at completion, so an aborted store never lands.
  always_ff @(posedge clock) begin
    if (access_s && is_store_r && !oor_s) begin
      mem_r[index_s] <= store_data_r;
    end
  end

`ifdef DMEM_OOR_FAULT_EN
  logic fault_r;

  // Fault flag pulses alongside valid for out-of-range completions.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= access_s && oor_s;
    end
  end

  assign bus.fault = fault_r;
`endif

  assign bus.ready     = ready_r;
  assign bus.valid     = valid_r;
  assign bus.load_data = load_data_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (LATENCY 2 and 0) against a behavioural memory model.
module tb_dmem_responder;

  logic        clock = 1'b0;
  int          errors = 0;
  int          checks = 0;

  logic        ld_d   [2];
  logic        st_d   [2];
  logic [19:0] ad_d   [2];
  logic [31:0] sd_d   [2];
  logic        rst_d  [2];
  logic        obs_ready [2];
  logic        obs_valid [2];
  logic [31:0] obs_ld    [2];
  logic        obs_fault [2];

  logic [31:0] mdl [2][1024];
  logic [31:0] mld [2];
  int          lat [2];

  always #5 clock = ~clock;

  dmem_responder_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) bus0 ();
  dmem_responder_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) bus1 ();

  dmem_responder #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .INDEX_BITS(10), .LATENCY(2))
    u_dut0 (.clock(clock), .reset(rst_d[0]), .bus(bus0));
  dmem_responder #(.CORE(1), .DATA_WIDTH(32), .ADDRESS_BITS(20), .INDEX_BITS(10), .LATENCY(0))
    u_dut1 (.clock(clock), .reset(rst_d[1]), .bus(bus1));

  assign bus0.load       = ld_d[0];
  assign bus0.store      = st_d[0];
  assign bus0.address    = ad_d[0];
  assign bus0.store_data = sd_d[0];
  assign bus1.load       = ld_d[1];
  assign bus1.store      = st_d[1];
  assign bus1.address    = ad_d[1];
  assign bus1.store_data = sd_d[1];
  assign obs_ready[0] = bus0.ready;
  assign obs_valid[0] = bus0.valid;
  assign obs_ld[0]    = bus0.load_data;
  assign obs_ready[1] = bus1.ready;
  assign obs_valid[1] = bus1.valid;
  assign obs_ld[1]    = bus1.load_data;
`ifdef DMEM_OOR_FAULT_EN
  assign obs_fault[0] = bus0.fault;
  assign obs_fault[1] = bus1.fault;
`else
  assign obs_fault[0] = 1'b0;
  assign obs_fault[1] = 1'b0;
`endif

  function automatic bit is_oor(input logic [19:0] a);
`ifdef DMEM_OOR_FAULT_EN
    return a[19:10] != 10'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on DUT d. Caller is at a negedge. noise toggles load during the busy window;
  // rst_at >= 0 pulls reset low at that busy-cycle index and abandons the transaction.
  task automatic req(input int d, input bit l, input bit s, input logic [19:0] a,
                     input logic [31:0] data, input bit noise, input int rst_at);
    int          n;
    bit          oor;
    logic [9:0]  idx;
    logic [31:0] exp_ld;
    n = 0;
    while (!obs_ready[d] && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("ready_before_accept", 32'(obs_ready[d]), 32'd1);
    ld_d[d] = l; st_d[d] = s; ad_d[d] = a; sd_d[d] = data;
    @(posedge clock);
    #1;
    ld_d[d] = 1'b0; st_d[d] = 1'b0;
    oor = is_oor(a);
    idx = a[9:0];
    exp_ld = s ? mld[d] : (oor ? 32'd0 : mdl[d][idx]);
    for (int j = 0; j <= lat[d] + 1; j++) begin
      @(negedge clock);
      if (rst_at == j) begin
        rst_d[d] = 1'b0;
        #1;
        check("reset_ready", 32'(obs_ready[d]), 32'd1);
        check("reset_valid", 32'(obs_valid[d]), 32'd0);
        check("reset_load_data", obs_ld[d], 32'd0);
        mld[d] = 32'd0;
        @(negedge clock);
        rst_d[d] = 1'b1;
        check("post_reset_valid", 32'(obs_valid[d]), 32'd0);
        return;
      end
      if (noise) begin
        ld_d[d] = (j < lat[d] + 1) && (j % 2 == 0);
        ad_d[d] = 20'h00001;
      end
      check("busy_ready_low", 32'(obs_ready[d]), 32'd0);
      check("valid_timing", 32'(obs_valid[d]), (j == lat[d] + 1) ? 32'd1 : 32'd0);
      if (j == lat[d] + 1) begin
        check("load_data", obs_ld[d], exp_ld);
        check("fault", 32'(obs_fault[d]), 32'(oor));
      end
    end
    if (s && !oor) mdl[d][idx] = data;
    mld[d] = exp_ld;
    @(negedge clock);
    check("ready_returns", 32'(obs_ready[d]), 32'd1);
    check("single_valid", 32'(obs_valid[d]), 32'd0);
    check("load_data_hold", obs_ld[d], mld[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d;
    int          op;
    logic [19:0] a;
    logic [9:0]  hi;
    lat[0] = 2;
    lat[1] = 0;
    for (int k = 0; k < 2; k++) begin
      ld_d[k] = 1'b0; st_d[k] = 1'b0; ad_d[k] = 20'd0; sd_d[k] = 32'd0;
      rst_d[k] = 1'b0; mld[k] = 32'd0;
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", 32'(obs_ready[k]), 32'd1);
      check("rst_valid", 32'(obs_valid[k]), 32'd0);
      check("rst_load_data", obs_ld[k], 32'd0);
      check("rst_fault", 32'(obs_fault[k]), 32'd0);
    end
    rst_d[0] = 1'b1;
    rst_d[1] = 1'b1;
    @(negedge clock);

    // Preload low words on both instances
    for (int k = 0; k < 16; k++) begin
      req(0, 1'b0, 1'b1, 20'(k), 32'h1000_0000 + 32'(k), 1'b0, -1);
      req(1, 1'b0, 1'b1, 20'(k), (k == 0) ? 32'hA : ((k == 1) ? 32'hB : $urandom), 1'b0, -1);
    end

    // Store then load, LATENCY 2
    req(0, 1'b0, 1'b1, 20'h0003A, 32'hDEADBEEF, 1'b0, -1);
    req(0, 1'b1, 1'b0, 20'h0003A, 32'h0, 1'b0, -1);
    // Load and store together behave as a store
    req(0, 1'b1, 1'b1, 20'h00007, 32'h0000CAFE, 1'b0, -1);
    req(0, 1'b1, 1'b0, 20'h00007, 32'h0, 1'b0, -1);
    // Requests while busy are ignored
    req(0, 1'b1, 1'b0, 20'h00003, 32'h0, 1'b1, -1);
    req(1, 1'b0, 1'b1, 20'h00009, 32'h55AA55AA, 1'b1, -1);
    // Reset in the middle of a store
    req(0, 1'b0, 1'b1, 20'h00005, 32'h11111111, 1'b0, 0);
    req(0, 1'b1, 1'b0, 20'h00005, 32'h0, 1'b0, -1);
    // LATENCY 0 back-to-back loads
    req(1, 1'b1, 1'b0, 20'h00000, 32'h0, 1'b0, -1);
    req(1, 1'b1, 1'b0, 20'h00001, 32'h0, 1'b0, -1);
    // Upper address bits: aliasing or fault
    req(0, 1'b0, 1'b1, 20'h00400, 32'h12345678, 1'b0, -1);
    req(0, 1'b1, 1'b0, 20'h00000, 32'h0, 1'b0, -1);
    req(0, 1'b1, 1'b0, 20'h00400, 32'h0, 1'b0, -1);

    // Random traffic within the preloaded window, sometimes with upper bits set
    for (int i = 0; i < 40; i++) begin
      d  = i % 2;
      hi = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1, 1023)) : 10'd0;
      a  = {hi, 10'($urandom_range(0, 15))};
      op = $urandom_range(0, 2);
      req(d, op != 1, op != 0, a, $urandom, 1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
